// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin writeback arbiter merging ALU and load results
// into a single GPR write port, plus a pending-write scoreboard that stalls
// instruction issue on RAW/WAW hazards (no bypass).
module gpr_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_req,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  output logic              issue_stall,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_dest,
  output logic [DATA_W-1:0] write_data,
  output logic [NREG-1:0]   pending
);

  // rr=0 favours the ALU on contention, rr=1 favours the load path
  logic              rr;
  logic              alu_gnt_p0;
  logic              mem_gnt_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] dest_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] dest_p1;
  logic [DATA_W-1:0] data_p1;
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_nxt;
  logic              issue_fire;

  // Stage p0: grant selection; nothing is granted while reset is held
  always_comb begin
    alu_gnt_p0 = 1'b0;
    mem_gnt_p0 = 1'b0;
    if (!rst) begin
      if (alu_valid && (!mem_valid || !rr)) begin
        alu_gnt_p0 = 1'b1;
      end else if (mem_valid) begin
        mem_gnt_p0 = 1'b1;
      end
    end
  end

  assign alu_ready = alu_gnt_p0;
  assign mem_ready = mem_gnt_p0;
  assign vld_p0    = alu_gnt_p0 | mem_gnt_p0;
  assign dest_p0   = alu_gnt_p0 ? alu_dest : mem_dest;
  assign data_p0   = alu_gnt_p0 ? alu_data : mem_data;

  // Hazard check looks only at committed scoreboard state: no forwarding
  assign issue_stall = issue_req &&
                       (pending_q[issue_rs1] || pending_q[issue_rs2] || pending_q[issue_dest]);
  assign issue_fire  = issue_req && !issue_stall;

  // Scoreboard next state: the retiring write clears first so a same-edge issue re-sets the bit
  always_comb begin
    pending_nxt = pending_q;
    if (vld_p1) begin
      pending_nxt[dest_p1] = 1'b0;
    end
    if (issue_fire) begin
      pending_nxt[issue_dest] = 1'b1;
    end
  end

  // Stage p0 -> p1: register the accepted write, advance rr, update scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      vld_p1    <= 1'b0;
      dest_p1   <= '0;
      data_p1   <= '0;
      pending_q <= '0;
    end else begin
      vld_p1    <= vld_p0;
      pending_q <= pending_nxt;
      if (vld_p0) begin
        rr      <= alu_gnt_p0;
        dest_p1 <= dest_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign write_en   = vld_p1;
  assign write_dest = dest_p1;
  assign write_data = data_p1;
  assign pending    = pending_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of arbitration and scoreboard.
module tb_gpr_wb_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_req;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              issue_stall;
  logic              write_en;
  logic [ADDR_W-1:0] write_dest;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;

  int n_tests = 0;
  int n_fail  = 0;

  gpr_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_req(issue_req), .issue_dest(issue_dest), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    issue_req = 1'b0; issue_dest = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    alu_valid = 1'b1; mem_valid = 1'b1; issue_req = 1'b1; issue_dest = 3'd2;
    #1;
    n_tests++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: alu=%b mem=%b required 0 0", alu_ready, mem_ready);
    end
    tick();
    tick();
    n_tests++;
    if (write_en !== 1'b0 || write_dest !== 3'd0 || write_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_write: en=%b dest=%0d data=%h required 0 0 0000", write_en, write_dest, write_data);
    end
    n_tests++;
    if (pending !== 8'h00) begin
      n_fail++; $display("FAIL reset_pending: got %h required 00", pending);
    end
  endtask

  task automatic test_single_alu();
    rst = 1'b0;
    idle();
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
    #1;
    n_tests++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: alu=%b mem=%b required 1 0", alu_ready, mem_ready);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (write_en !== 1'b1 || write_dest !== 3'd3 || write_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_write: en=%b dest=%0d data=%h required 1 3 1234", write_en, write_dest, write_data);
    end
    tick();
    n_tests++;
    if (write_en !== 1'b0 || write_dest !== 3'd3 || write_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_hold: en=%b dest=%0d data=%h required 0 3 1234", write_en, write_dest, write_data);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] prev_dest;
    do_reset();
    alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'hA001;
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hB002;
    prev_dest = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL contention_grant[%0d]: alu=%b mem=%b required %b %b",
                           i, alu_ready, mem_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        n_tests++;
        if (write_en !== 1'b1 || write_dest !== prev_dest) begin
          n_fail++; $display("FAIL contention_write[%0d]: en=%b dest=%0d required 1 %0d", i, write_en, write_dest, prev_dest);
        end
      end
      prev_dest = (i % 2 == 0) ? 3'd1 : 3'd2;
      tick();
    end
    idle();
    #1;
    n_tests++;
    if (write_en !== 1'b1 || write_dest !== 3'd2 || write_data !== 16'hB002) begin
      n_fail++; $display("FAIL contention_last: en=%b dest=%0d data=%h required 1 2 b002", write_en, write_dest, write_data);
    end
    tick();
    n_tests++;
    if (write_en !== 1'b0) begin
      n_fail++; $display("FAIL contention_drain: en=%b required 0", write_en);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    issue_req = 1'b1; issue_dest = 3'd5; issue_rs1 = 3'd0; issue_rs2 = 3'd0;
    #1;
    n_tests++;
    if (issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_first_issue: stall=%b required 0", issue_stall);
    end
    tick();
    issue_req = 1'b0;
    #1;
    n_tests++;
    if (pending !== 8'h20) begin
      n_fail++; $display("FAIL hazard_pending: got %h required 20", pending);
    end
    issue_req = 1'b1; issue_dest = 3'd1; issue_rs1 = 3'd5; issue_rs2 = 3'd0;
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h5555;
    #1;
    n_tests++;
    if (issue_stall !== 1'b1) begin
      n_fail++; $display("FAIL hazard_raw_stall: stall=%b required 1", issue_stall);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if (write_en !== 1'b1 || write_dest !== 3'd5 || issue_stall !== 1'b1) begin
      n_fail++; $display("FAIL hazard_wb_cycle: en=%b dest=%0d stall=%b required 1 5 1", write_en, write_dest, issue_stall);
    end
    tick();
    n_tests++;
    if (issue_stall !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL hazard_release: stall=%b pending=%h required 0 00", issue_stall, pending);
    end
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h4444;
    tick();
    alu_valid = 1'b0;
    issue_req = 1'b1; issue_dest = 3'd4; issue_rs1 = 3'd1; issue_rs2 = 3'd2;
    #1;
    n_tests++;
    if (write_en !== 1'b1 || issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL collision_setup: en=%b stall=%b required 1 0", write_en, issue_stall);
    end
    tick();
    issue_req = 1'b0;
    #1;
    n_tests++;
    if (pending !== 8'h10) begin
      n_fail++; $display("FAIL collision_set_wins: pending=%h required 10", pending);
    end
  endtask

  task automatic test_waw();
    do_reset();
    issue_req = 1'b1; issue_dest = 3'd6; issue_rs1 = 3'd0; issue_rs2 = 3'd0;
    tick();
    issue_dest = 3'd6; issue_rs1 = 3'd1; issue_rs2 = 3'd2;
    #1;
    n_tests++;
    if (issue_stall !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall: stall=%b required 1", issue_stall);
    end
    tick();
    n_tests++;
    if (pending !== 8'h40) begin
      n_fail++; $display("FAIL waw_pending: pending=%h required 40", pending);
    end
    issue_req = 1'b0; issue_rs1 = 3'd6;
    #1;
    n_tests++;
    if (issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_no_req: stall=%b required 0", issue_stall);
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    issue_req = 1'b1; issue_dest = 3'd7;
    tick();
    issue_req = 1'b0;
    alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0A0A;
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h0B0B;
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (write_en !== 1'b1 || alu_ready !== 1'b0 || mem_ready !== 1'b0 || pending !== 8'h80) begin
      n_fail++; $display("FAIL midreset_before: en=%b alu=%b mem=%b pending=%h required 1 0 0 80",
                         write_en, alu_ready, mem_ready, pending);
    end
    tick();
    n_tests++;
    if (write_en !== 1'b0 || pending !== 8'h00 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_after: en=%b pending=%h alu=%b mem=%b required 0 00 0 0",
                         write_en, pending, alu_ready, mem_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_alu_first: alu=%b mem=%b required 1 0", alu_ready, mem_ready);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (write_en !== 1'b1 || write_dest !== 3'd1 || write_data !== 16'h0A0A) begin
      n_fail++; $display("FAIL midreset_write: en=%b dest=%0d data=%h required 1 1 0a0a", write_en, write_dest, write_data);
    end
    tick();
  endtask

  // Randomized run against a transaction-level model: "last winner yields",
  // a set of outstanding destinations, and the one write expected next cycle.
  task automatic test_random();
    bit                m_last_alu;
    logic [NREG-1:0]   m_pend;
    bit                m_wen;
    logic [ADDR_W-1:0] m_wdest;
    logic [DATA_W-1:0] m_wdata;
    bit                g_alu, g_mem, m_stall;
    do_reset();
    m_last_alu = 1'b0; m_pend = '0; m_wen = 1'b0; m_wdest = '0; m_wdata = '0;
    g_alu = 1'b0; g_mem = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!(alu_valid && !g_alu)) begin
        alu_valid = $urandom_range(0, 1);
        alu_dest  = ADDR_W'($urandom);
        alu_data  = DATA_W'($urandom);
      end
      if (!(mem_valid && !g_mem)) begin
        mem_valid = $urandom_range(0, 1);
        mem_dest  = ADDR_W'($urandom);
        mem_data  = DATA_W'($urandom);
      end
      issue_req  = ($urandom_range(0, 2) == 0);
      issue_dest = ADDR_W'($urandom);
      issue_rs1  = ADDR_W'($urandom);
      issue_rs2  = ADDR_W'($urandom);
      g_alu = 1'b0; g_mem = 1'b0;
      if (!rst) begin
        if (alu_valid && mem_valid) begin
          if (m_last_alu) g_mem = 1'b1; else g_alu = 1'b1;
        end else if (alu_valid) begin
          g_alu = 1'b1;
        end else if (mem_valid) begin
          g_mem = 1'b1;
        end
      end
      m_stall = issue_req && (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_dest]);
      #1;
      n_tests++;
      if (alu_ready !== g_alu || mem_ready !== g_mem || issue_stall !== m_stall) begin
        n_fail++; $display("FAIL rand_comb[%0d]: alu=%b mem=%b stall=%b required %b %b %b",
                           cyc, alu_ready, mem_ready, issue_stall, g_alu, g_mem, m_stall);
      end
      n_tests++;
      if (write_en !== m_wen || write_dest !== m_wdest || write_data !== m_wdata || pending !== m_pend) begin
        n_fail++; $display("FAIL rand_state[%0d]: en=%b dest=%0d data=%h pend=%h required %b %0d %h %h",
                           cyc, write_en, write_dest, write_data, pending, m_wen, m_wdest, m_wdata, m_pend);
      end
      if (rst) begin
        m_last_alu = 1'b0; m_pend = '0; m_wen = 1'b0; m_wdest = '0; m_wdata = '0;
      end else begin
        if (m_wen) m_pend[m_wdest] = 1'b0;
        if (issue_req && !m_stall) m_pend[issue_dest] = 1'b1;
        m_wen = g_alu || g_mem;
        if (g_alu) begin
          m_wdest = alu_dest; m_wdata = alu_data; m_last_alu = 1'b1;
        end else if (g_mem) begin
          m_wdest = mem_dest; m_wdata = mem_data; m_last_alu = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_alu();
    test_contention();
    test_hazard();
    test_collision();
    test_waw();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameters: DATA_W, default 16, GPR data width; ADDR_W, default 3, GPR index width; NREG, default 8, GPR count (2**ADDR_W).
REQ-002 clk  input  1  sole clock, all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_dest  input  ADDR_W  ALU destination register.
REQ-006 alu_data  input  DATA_W  ALU result.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 mem_valid  input  1  load writeback request.
REQ-009 mem_dest  input  ADDR_W  load destination register.
REQ-010 mem_data  input  DATA_W  load data.
REQ-011 mem_ready  output  1  load request accepted this cycle.
REQ-012 issue_req  input  1  decode wants to issue an instruction.
REQ-013 issue_dest  input  ADDR_W  destination of issuing instruction.
REQ-014 issue_rs1, issue_rs2  input  ADDR_W each  source registers of issuing instruction.
REQ-015 issue_stall  output  1  issue blocked by hazard.
REQ-016 write_en  output  1  to GPR file write enable.
REQ-017 write_dest  output  ADDR_W  to GPR file destination.
REQ-018 write_data  output  DATA_W  to GPR file data.
REQ-019 pending  output  NREG  scoreboard, bit i = register i awaiting writeback.

Function
REQ-020 Handshake: a request is accepted on a posedge where valid && ready; requester holds dest/data stable while valid && !ready.
REQ-021 alu_ready and mem_ready are combinational, never both 1, and 0 while rst is high.
REQ-022 Only one valid: that requester gets ready=1 in the same cycle.
REQ-023 Both valid: round-robin pointer rr selects; rr=0 grants ALU, rr=1 grants MEM.
REQ-024 rr updates only on acceptance: ALU grant sets rr=1, MEM grant sets rr=0; no acceptance leaves rr unchanged.
REQ-025 Latency: accepted dest/data appear on write_dest/write_data with write_en=1 in the cycle after acceptance (registered outputs); GPR file commits at the following edge.
REQ-026 Cycle with no acceptance: write_en=0 next cycle; write_dest/write_data hold previous values.
REQ-027 Back-to-back acceptances produce write_en=1 on consecutive cycles, one write per cycle, no bubbles.
REQ-028 Scoreboard set: pending[issue_dest] sets on a posedge where issue_req && !issue_stall.
REQ-029 Scoreboard clear: pending[write_dest] clears on the posedge where write_en=1 (same edge the GPR file commits).
REQ-030 Set and clear of same bit on same edge: set wins (newer producer outstanding).
REQ-031 issue_stall = issue_req && (pending[issue_rs1] || pending[issue_rs2] || pending[issue_dest]); combinational; no bypass.
REQ-032 issue_stall=0 whenever issue_req=0.
REQ-033 Writeback to a register with pending=0 is legal: GPR write performed, scoreboard unchanged.
REQ-034 Requester arbitration is independent of scoreboard state; writebacks never stall.

Reset
REQ-035 While rst=1 at a posedge: rr=0, pending=0, write_en=0, write_dest=0, write_data=0; no acceptance, no scoreboard set.
REQ-036 Reset mid-operation: a request valid during reset is not accepted; an in-flight write_en=1 is dropped at the reset edge.
REQ-037 First cycle after rst deasserts: normal arbitration, ALU preferred on contention.

Verification
REQ-038 Single ALU: alu_valid=1, dest=3, data=16'h1234 -> alu_ready=1 same cycle; next cycle write_en=1, write_dest=3, write_data=16'h1234.
REQ-039 Contention after reset: both valid for 4 cycles (ALU dest 1, MEM dest 2) -> grants ALU, MEM, ALU, MEM; write_en=1 for 4 consecutive cycles.
REQ-040 Hazard: issue_dest=5 issued -> pending=8'h20; next issue with rs1=5 -> issue_stall=1; ALU writeback to 5 -> stall drops the cycle after write_en=1.
REQ-041 Set/clear collision: write_en=1 to reg 4 while issue_dest=4 issues unstalled -> pending[4]=1 after the edge.
REQ-042 WAW: pending[6]=1, issue_dest=6 with clean sources -> issue_stall=1, pending unchanged.
REQ-043 Reset mid-stream: assert rst with both valid and write_en=1 -> next cycle write_en=0, pending=0, alu_ready=mem_ready=0; after release, ALU granted first.
